f_fetch: RTL and testbench

Fetch-stage unit that owns the program counter and produces the instruction/PC pair captured by the IF/ID pipeline register. It drives the instruction-memory address, selects the next PC from sequential increment or a D-stage redirect (branch/jump), honours the global freeze from the hazard unit, and flags illegal fetch addresses. Its `out_instr`/`out_pc` connect directly to the IF/ID register's instruction and PC inputs, and both blocks share the same `freeze`.

---
 rtl/f_fetch.sv | 81 ++++++++
 tb/tb_f_fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/f_fetch.sv
// Fetch stage: owns the PC, drives the instruction-memory address, and hands instr/PC to IF/ID.
// Optional macro F_FETCH_DELAY_SLOT_EN: when defined, the word fetched during an accepted redirect is kept.
module f_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h00003000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_adel
);

  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [32:0] pc_ext;
  logic        illegal;
  logic        accept;
  logic        squash;

  assign accept = redirect_valid & ~freeze;

  // A frozen stage drops the redirect; the stalled branch in D reasserts it later.
  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (freeze) begin
      pc_next = pc_reg;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // 33-bit compare so RESET_PC + 4*IMEM_WORDS cannot wrap.
  assign pc_ext  = {1'b0, pc_reg};
  assign illegal = (pc_reg[1:0] != 2'b00) || (pc_ext < PC_LO) || (pc_ext >= PC_HI);

`ifdef F_FETCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  logic kill_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_reg <= 1'b0;
    end else if (!freeze) begin
      kill_reg <= accept;
    end
  end

  // The wrong-path word is zeroed while the redirect is taken; kill keeps the
  // output quiet if a freeze follows, and releases once the stage moves again.
  assign squash = accept | (kill_reg & freeze);
`endif

  assign i_inst_addr = pc_reg;
  assign out_pc      = pc_reg;
  assign out_adel    = illegal;
  assign out_instr   = (illegal || squash) ? 32'h0 : i_inst_rdata;

`ifdef F_FETCH_DELAY_SLOT_EN
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_f_fetch.sv
// Directed bench for f_fetch: expectations are queued as each step is driven, then popped and checked.
module tb_f_fetch;

`ifdef F_FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        freeze = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_adel;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        adel;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  f_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .freeze         (freeze),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .i_inst_addr    (i_inst_addr),
    .i_inst_rdata   (i_inst_rdata),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_adel       (out_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
  endfunction

  assign i_inst_rdata = mem(i_inst_addr);

  // flush: this cycle's word is a wrong-path word that only the no-delay-slot build zeroes
  task automatic push(input string tag, input logic [31:0] pc, input logic adel, input logic flush);
    exp_t e;
    e.tag   = tag;
    e.pc    = pc;
    e.adel  = adel;
    e.instr = (adel || (flush && !DS)) ? 32'h0 : mem(pc);
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (out_pc === e.pc) else begin
      fails++;
      $error("FAIL %s out_pc got %h expected %h", e.tag, out_pc, e.pc);
    end
    tests++;
    assert (i_inst_addr === e.pc) else begin
      fails++;
      $error("FAIL %s i_inst_addr got %h expected %h", e.tag, i_inst_addr, e.pc);
    end
    tests++;
    assert (out_adel === e.adel) else begin
      fails++;
      $error("FAIL %s out_adel got %b expected %b", e.tag, out_adel, e.adel);
    end
    tests++;
    assert (out_instr === e.instr) else begin
      fails++;
      $error("FAIL %s out_instr got %h expected %h", e.tag, out_instr, e.instr);
    end
    $display("[TB] %-10s pc=%h adel=%b instr=%h", e.tag, out_pc, out_adel, out_instr);
  endtask

  // Drive one cycle's inputs, check the current fetch, then advance one edge.
  task automatic step(input string tag, input logic frz, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] exp_pc, input logic exp_adel, input logic flush);
    freeze         = frz;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    push(tag, exp_pc, exp_adel, flush);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    push("reset", 32'h3000, 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;

    // Sequential run
    step("seq0", 0, 0, 32'h0, 32'h3000, 0, 0);
    step("seq1", 0, 0, 32'h0, 32'h3004, 0, 0);
    // Freeze with a pending redirect: PC holds, redirect dropped
    step("frz0", 1, 1, 32'h3100, 32'h3008, 0, 0);
    step("frz1", 1, 1, 32'h3100, 32'h3008, 0, 0);
    step("rel", 0, 1, 32'h3100, 32'h3008, 0, 1);
    step("tgt3100", 0, 0, 32'h0, 32'h3100, 0, 0);
    // Redirect chain: 0x3104 -> 0x3010 -> 0x3040
    step("rd3010", 0, 1, 32'h3010, 32'h3104, 0, 1);
    step("rd3040", 0, 1, 32'h3040, 32'h3010, 0, 1);
    step("tgt3040", 0, 0, 32'h0, 32'h3040, 0, 0);
    // Misaligned target is loaded verbatim and keeps stepping by 4
    step("rd3042", 0, 1, 32'h3042, 32'h3044, 0, 1);
    step("mis3042", 0, 0, 32'h0, 32'h3042, 1, 0);
    step("rd6ff8", 0, 1, 32'h6FF8, 32'h3046, 1, 1);
    // Upper bound of instruction memory
    step("hi6ff8", 0, 0, 32'h0, 32'h6FF8, 0, 0);
    step("hi6ffc", 0, 0, 32'h0, 32'h6FFC, 0, 0);
    step("hi7000", 0, 0, 32'h0, 32'h7000, 1, 0);
    step("rdwrap", 0, 1, 32'hFFFF_FFFC, 32'h7004, 1, 1);
    // 32-bit wrap and below-range addresses
    step("wrapfc", 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0);
    step("rd3050", 0, 1, 32'h3050, 32'h0000_0000, 1, 1);
    // Freeze right after a redirect: kill keeps the output quiet
    step("kill0", 1, 0, 32'h0, 32'h3050, 0, 1);
    step("kill1", 1, 1, 32'h3200, 32'h3050, 0, 1);

    // Reset while frozen: PC returns to RESET_PC and kill clears
    reset = 1'b1;
    freeze = 1'b1;
    @(posedge clk);
    #1;
    push("rstfrz", 32'h3000, 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;
    step("postrst", 1, 0, 32'h0, 32'h3000, 0, 0);
    step("resume", 0, 0, 32'h0, 32'h3000, 0, 0);
    step("resume2", 0, 0, 32'h0, 32'h3004, 0, 0);

    // Reset while a redirect is presented
    redirect_valid = 1'b1;
    redirect_pc = 32'h3300;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    redirect_valid = 1'b0;
    #1;
    push("rstrd", 32'h3000, 1'b0, 1'b0);
    check_pop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
